cap_sense_driver: RTL

CAP_SENSE_DRIVER -- requirements
Module: cap_sense_driver

---
 rtl/cap_sense_driver.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cap_sense_driver.sv
// Capacitive touch pad driver: charge, release, time the discharge,
// calibrate an untouched baseline and debounce the touch decision.
module cap_sense_driver #(
   parameter int          CHARGE_CYCLES  = 16,
   parameter int          TIMEOUT_CYCLES = 4096,
   parameter int          CAL_SHIFT      = 3,
   parameter logic [31:0] THRESHOLD      = 32'd100
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        sensor_in,
   input  logic [31:0] final_count,
   output logic        sensor_oe,
   output logic        sensor_drive,
   output logic        start,
   output logic        capacitor_charged,
   output logic [31:0] sample,
   output logic        sample_valid,
   output logic [31:0] baseline,
   output logic        calibrated,
   output logic        touched,
   output logic        timeout
);

   localparam int ACC_W = 32 + CAL_SHIFT;
   localparam logic [31:0] CHG_LAST = 32'(CHARGE_CYCLES - 1);
   localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [CAL_SHIFT:0] CAL_LAST =
      (CAL_SHIFT + 1)'((1 << CAL_SHIFT) - 1);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      CHARGE,
      RELEASE,
      SETTLE,
      EVAL
   } state_t;

   state_t      state, state_nx;
   logic [31:0] cnt, cnt_nx;
   logic        to_nx;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + 32'd1;
      to_nx    = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_nx = '0;
            if (enable) state_nx = CLEAR;
         end
         CLEAR: begin
            cnt_nx   = '0;
            state_nx = CHARGE;
         end
         CHARGE: begin
            if (cnt == CHG_LAST) begin
               cnt_nx   = '0;
               state_nx = RELEASE;
            end
         end
         RELEASE: begin
            // A discharge seen on the final cycle still counts as valid.
            if (!sensor_in) begin
               cnt_nx   = '0;
               state_nx = SETTLE;
            end else if (cnt == TO_LAST) begin
               cnt_nx   = '0;
               state_nx = IDLE;
               to_nx    = 1'b1;
            end
         end
         SETTLE: begin
            cnt_nx   = '0;
            state_nx = EVAL;
         end
         EVAL: begin
            cnt_nx   = '0;
            state_nx = enable ? CLEAR : IDLE;
         end
         default: begin
            cnt_nx   = '0;
            state_nx = IDLE;
         end
      endcase
   end

   // Pad controls are registered from the next state so they are glitch-free.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state             <= IDLE;
         cnt               <= '0;
         sensor_oe         <= 1'b0;
         sensor_drive      <= 1'b0;
         start             <= 1'b0;
         capacitor_charged <= 1'b0;
         timeout           <= 1'b0;
      end else begin
         state             <= state_nx;
         cnt               <= cnt_nx;
         sensor_oe         <= (state_nx == CHARGE);
         sensor_drive      <= (state_nx == CHARGE);
         start             <= (state_nx != CLEAR);
         capacitor_charged <= (state_nx == RELEASE);
         timeout           <= to_nx;
      end
   end

   logic             accept;
   logic [ACC_W-1:0] acc, acc_sum;
   logic [CAL_SHIFT:0] cal_cnt;
   logic [32:0]      lim_wide;
   logic [31:0]      limit;
   logic             above;
   logic             pend;

   assign accept   = (state == EVAL) && (final_count != 32'd0);
   assign acc_sum  = acc + ACC_W'(final_count);
   assign lim_wide = {1'b0, baseline} + {1'b0, THRESHOLD};
   assign limit    = lim_wide[32] ? 32'hFFFF_FFFF : lim_wide[31:0];
   assign above    = final_count > limit;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sample       <= '0;
         sample_valid <= 1'b0;
         baseline     <= '0;
         calibrated   <= 1'b0;
         touched      <= 1'b0;
         acc          <= '0;
         cal_cnt      <= '0;
         pend         <= 1'b0;
      end else begin
         sample_valid <= accept;
         if (accept) begin
            sample <= final_count;
            if (!calibrated) begin
               acc     <= acc_sum;
               cal_cnt <= cal_cnt + 1'b1;
               if (cal_cnt == CAL_LAST) begin
                  baseline   <= acc_sum[CAL_SHIFT +: 32];
                  calibrated <= 1'b1;
               end
            end else if (above != touched) begin
               // Flip only on the second consecutive disagreeing sample.
               if (pend) begin
                  touched <= above;
                  pend    <= 1'b0;
               end else begin
                  pend <= 1'b1;
               end
            end else begin
               pend <= 1'b0;
            end
         end
      end
   end

endmodule
